// File: rtl/mem_backing_store.sv
// rtl/mem_backing_store.sv - word-wide backing memory for cache refills and write-backs
// Fixed-latency req/ready handshake; four little-endian byte lanes.
module mem_backing_store #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata [0:3],
  output logic [7:0]  rdata [0:3],
  output logic        ready,
  output logic        busy
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int WORDS    = 1 << IDX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            count;
  logic [IDX_BITS-1:0]   idx_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic                  access;
  logic [31:0]           mem [WORDS];
  logic                  addr_unused;

  // Byte offset and aliased upper bits do not take part in decoding.
  assign addr_unused = ^{addr[31:ADDR_BITS], addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: if (req) state_next = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (count == 4'd0) begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      for (int i = 0; i < 4; i++) rdata[i] <= 8'h00;
    end else begin
      if (state == IDLE && req) begin
        count   <= 4'(LATENCY - 1);
        idx_q   <= addr[ADDR_BITS-1:2];
        we_q    <= we;
        wdata_q <= {wdata[3], wdata[2], wdata[1], wdata[0]};
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      // rdata is only refreshed by a completing read; writes leave it alone.
      if (access && !we_q) begin
        for (int i = 0; i < 4; i++) rdata[i] <= mem[idx_q][8*i +: 8];
      end
    end
  end

  // Storage is deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (access && we_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_backing_store.sv
// tb/tb_mem_backing_store.sv - bench for mem_backing_store at LATENCY 4 and 1
module tb_mem_backing_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        req4, we4, ready4, busy4;
  logic        req1, we1, ready1, busy1;
  logic [31:0] addr4, addr1;
  logic [7:0]  wdata4 [0:3];
  logic [7:0]  rdata4 [0:3];
  logic [7:0]  wdata1 [0:3];
  logic [7:0]  rdata1 [0:3];

  always #5 clk = ~clk;

  mem_backing_store #(.ADDR_BITS(12), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4),
    .wdata(wdata4), .rdata(rdata4), .ready(ready4), .busy(busy4)
  );

  mem_backing_store #(.ADDR_BITS(12), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .busy(busy1)
  );

  typedef struct {
    int          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        tbl[$];
  logic [31:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input int sel);
    if (sel != 0) return {rdata1[3], rdata1[2], rdata1[1], rdata1[0]};
    return {rdata4[3], rdata4[2], rdata4[1], rdata4[0]};
  endfunction

  function automatic logic rdy(input int sel);
    return (sel != 0) ? ready1 : ready4;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel != 0) ? busy1 : busy4;
  endfunction

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      req1 = r; we1 = w; addr1 = a;
      for (int i = 0; i < 4; i++) wdata1[i] = d[8*i +: 8];
    end else begin
      req4 = r; we4 = w; addr4 = a;
      for (int i = 0; i < 4; i++) wdata4[i] = d[8*i +: 8];
    end
  endtask

  // One complete transaction; expectation is queued at drive time, consumed at ready.
  task automatic op(input vec_t v, input string name);
    int   lat;
    int   k;
    exp_t e;
    lat = (v.sel != 0) ? 1 : 4;
    sb.push_back('{!v.we, v.data});
    drive(v.sel, 1'b1, v.we, v.addr, v.data);
    @(posedge clk); #1;
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (rdy(v.sel)) break;
    end
    drive(v.sel, 1'b0, 1'b0, 32'h0, 32'h0);
    e = sb.pop_front();
    if (!rdy(v.sel)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready_within_20", name);
      return;
    end
    check({name, "_latency"}, 32'(k), 32'(lat));
    check({name, "_busy_at_ready"}, 32'(bsy(v.sel)), 32'd1);
    if (e.is_read) begin
      check({name, "_rdata"}, rd_word(v.sel), e.data);
      last_rd[v.sel] = e.data;
    end else begin
      check({name, "_rdata_held"}, rd_word(v.sel), last_rd[v.sel]);
    end
    @(posedge clk); #1;
    check({name, "_ready_pulse_end"}, 32'(rdy(v.sel)), 32'd0);
    check({name, "_idle_after"}, 32'(bsy(v.sel)), 32'd0);
  endtask

  initial begin
    int cnt;
    int first;
    int second;

    tbl.push_back('{0, 1'b1, 32'h0000_0100, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b0, 32'h0000_0100, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 32'h0000_0000, 32'h11223344});
    tbl.push_back('{0, 1'b0, 32'h0000_1003, 32'h11223344});
    tbl.push_back('{0, 1'b1, 32'h0000_0FFC, 32'h0A0B0C0D});
    tbl.push_back('{0, 1'b0, 32'hFFFF_FFFF, 32'h0A0B0C0D});
    tbl.push_back('{0, 1'b1, 32'h0000_0204, 32'h55AA00FF});
    tbl.push_back('{0, 1'b0, 32'h0000_0100, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b1, 32'h0000_0008, 32'hA5A5A5A5});
    tbl.push_back('{1, 1'b0, 32'h0000_0008, 32'hA5A5A5A5});
    tbl.push_back('{1, 1'b1, 32'h0000_0008, 32'h12345678});
    tbl.push_back('{1, 1'b0, 32'h0000_000B, 32'h12345678});

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_ready4", 32'(ready4), 32'd0);
    check("rst_rdata4", rd_word(0), 32'h0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_rdata1", rd_word(1), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) op(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write must abort it without touching storage.
    op('{0, 1'b1, 32'h40, 32'h01020304}, "pre_abort_wr");
    drive(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_ready", 32'(ready4), 32'd0);
    check("abort_rdata", rd_word(0), 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(posedge clk); #1;
    op('{0, 1'b0, 32'h40, 32'h01020304}, "post_abort_rd");

    // Inputs wiggled during BUSY: latched read of 0x100 wins, single ready.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    cnt = 0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ready4) begin
        cnt++;
        if (first == 0) first = k;
      end
      if (k < 3) drive(0, ~req4, 1'b1, 32'h200, 32'hFFFFFFFF);
      else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("toggle_ready_count", 32'(cnt), 32'd1);
    check("toggle_ready_at", 32'(first), 32'd4);
    check("toggle_rdata", rd_word(0), 32'hDEADBEEF);
    op('{0, 1'b0, 32'h200, 32'h0}, "toggle_no_write");
    // The read above has no prior write to 0x200; only the accepted-write path could set it to FFs.
    checks++;
    if (rd_word(0) === 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL toggle_stray_write actual=%h required=not_ffffffff", rd_word(0));
    end

    // req held through ready and one more cycle: a second request follows,
    // leaving LATENCY+1 cycles strictly between the two ready pulses.
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    cnt = 0;
    first = 0;
    second = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ready4) begin
        cnt++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (first != 0 && k == first + 2) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("hold_ready_count", 32'(cnt), 32'd2);
    check("hold_first_at", 32'(first), 32'd4);
    check("hold_second_at", 32'(second), 32'd10);
    check("hold_rdata", rd_word(0), 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
